// File: rtl/watch_alarm_ctrl.sv
// Watch core: 1 Hz timebase, button-driven set FSM, daily alarm with timeout,
// and registered 8-digit display codes with 12/24 h formatting and blink.
module watch_alarm_ctrl #(
  parameter int TICK_DIV    = 100000000,
  parameter int ALARM_SECS  = 60,
  parameter int ALARM_RST_H = 7
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       add_btn,
  input  logic       sub_btn,
  input  logic       alarm_en_i,
  input  logic       fmt12_i,
  output logic [5:0] d1,
  output logic [5:0] d2,
  output logic [5:0] d3,
  output logic [5:0] d4,
  output logic [5:0] d5,
  output logic [5:0] d6,
  output logic [5:0] d7,
  output logic [5:0] d8,
  output logic       alarm_o,
  output logic       sec_tick_o
);

  localparam int CNT_W = $clog2(TICK_DIV);

  typedef enum logic [2:0] {
    ST_RUN    = 3'd0,
    ST_SET_H  = 3'd1,
    ST_SET_M  = 3'd2,
    ST_SET_AH = 3'd3,
    ST_SET_AM = 3'd4
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             blink_q, blink_d;
  logic [4:0]       hh_q, hh_d, ah_q, ah_d;
  logic [5:0]       mm_q, mm_d, ss_q, ss_d, am_q, am_d;
  logic             ring_q, ring_d;
  logic [7:0]       ring_cnt_q, ring_cnt_d;
  logic [2:0]       btn_prev_q;
  logic [7:0][5:0]  disp_q, disp_d;
  logic             alarm_q, sec_tick_q;

  logic [2:0] btn_ev;
  logic       mode_ev, edit_up, edit_dn, tick, count_go, trig, ring_clear;

  function automatic logic [5:0] step_mod(input logic [5:0] v, input logic [5:0] max,
                                          input logic up, input logic dn);
    if (up) return (v == max) ? 6'd0 : v + 6'd1;
    if (dn) return (v == 6'd0) ? max : v - 6'd1;
    return v;
  endfunction

  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] t;
    t = (v >= 6'd50) ? 4'd5 : (v >= 6'd40) ? 4'd4 : (v >= 6'd30) ? 4'd3 :
        (v >= 6'd20) ? 4'd2 : (v >= 6'd10) ? 4'd1 : 4'd0;
    return {t, 4'(v - 6'(t) * 6'd10)};
  endfunction

  function automatic logic [4:0] to_h12(input logic [4:0] h);
    if (h == 5'd0)  return 5'd12;
    if (h > 5'd12)  return h - 5'd12;
    return h;
  endfunction

  // Rising-edge events; mode masks add/sub, and add+sub together cancel.
  assign btn_ev  = {mode_btn, add_btn, sub_btn} & ~btn_prev_q;
  assign mode_ev = btn_ev[2];
  assign edit_up = ~mode_ev &  btn_ev[1] & ~btn_ev[0];
  assign edit_dn = ~mode_ev & ~btn_ev[1] &  btn_ev[0];
  assign tick    = (cnt_q == CNT_W'(TICK_DIV - 1));

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= ST_RUN;
    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d = state_q;
    if (mode_ev) begin
      unique case (state_q)
        ST_RUN:    state_d = ST_SET_H;
        ST_SET_H:  state_d = ST_SET_M;
        ST_SET_M:  state_d = ST_SET_AH;
        ST_SET_AH: state_d = ST_SET_AM;
        default:   state_d = ST_RUN;
      endcase
    end
  end

  // ---------------- Timebase, time/alarm datapath, ringing ----------------
  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    blink_d    = blink_q ^ (tick | (cnt_q == CNT_W'(TICK_DIV / 2 - 1)));
    hh_d       = hh_q;
    mm_d       = mm_q;
    ss_d       = ss_q;
    ah_d       = ah_q;
    am_d       = am_q;
    ring_d     = ring_q;
    ring_cnt_d = ring_cnt_q;

    // Leaving RUN freezes the time at hh:mm:00, so no carry on that edge.
    count_go = tick && (state_q inside {ST_RUN, ST_SET_AH, ST_SET_AM}) &&
               !(state_q == ST_RUN && mode_ev);
    if (count_go) begin
      if (ss_q == 6'd59) begin
        ss_d = '0;
        if (mm_q == 6'd59) begin
          mm_d = '0;
          hh_d = (hh_q == 5'd23) ? 5'd0 : hh_q + 5'd1;
        end else begin
          mm_d = mm_q + 6'd1;
        end
      end else begin
        ss_d = ss_q + 6'd1;
      end
    end
    if (state_q == ST_RUN && mode_ev) ss_d = '0;

    trig = count_go && (ss_q == 6'd59) && (hh_d == ah_q) && (mm_d == am_q) && alarm_en_i;

    unique case (state_q)
      ST_SET_H:  hh_d = 5'(step_mod({1'b0, hh_q}, 6'd23, edit_up, edit_dn));
      ST_SET_M:  mm_d = step_mod(mm_q, 6'd59, edit_up, edit_dn);
      ST_SET_AH: ah_d = 5'(step_mod({1'b0, ah_q}, 6'd23, edit_up, edit_dn));
      ST_SET_AM: am_d = step_mod(am_q, 6'd59, edit_up, edit_dn);
      default: ;
    endcase

    ring_clear = mode_ev | (state_q == ST_RUN & (edit_up | edit_dn)) | ~alarm_en_i;
    if (ring_clear) begin
      ring_d = 1'b0;
    end else if (trig) begin
      ring_d     = 1'b1;
      ring_cnt_d = '0;
    end else if (ring_q && tick) begin
      if (ring_cnt_q == 8'(ALARM_SECS - 1)) ring_d = 1'b0;
      else                                  ring_cnt_d = ring_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      blink_q    <= 1'b0;
      hh_q       <= '0;
      mm_q       <= '0;
      ss_q       <= '0;
      ah_q       <= 5'(ALARM_RST_H);
      am_q       <= '0;
      ring_q     <= 1'b0;
      ring_cnt_q <= '0;
      btn_prev_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      blink_q    <= blink_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      ah_q       <= ah_d;
      am_q       <= am_d;
      ring_q     <= ring_d;
      ring_cnt_q <= ring_cnt_d;
      btn_prev_q <= {mode_btn, add_btn, sub_btn};
    end
  end

  // ---------------- FSM: outputs (display encoding) ----------------
  logic [4:0] dh, hd;
  logic [5:0] dm;
  logic [7:0] hb, mb, sb;
  logic       show, colon, edit_h, edit_m, tens_on, pm;

  always_comb begin
    dh      = (state_q inside {ST_SET_AH, ST_SET_AM}) ? ah_q : hh_q;
    dm      = (state_q inside {ST_SET_AH, ST_SET_AM}) ? am_q : mm_q;
    pm      = (dh >= 5'd12);
    hd      = fmt12_i ? to_h12(dh) : dh;
    hb      = to_bcd({1'b0, hd});
    mb      = to_bcd(dm);
    sb      = to_bcd(ss_q);
    show    = ~blink_q;
    colon   = (state_q == ST_RUN) ? ~blink_q : 1'b1;
    edit_h  = (state_q inside {ST_SET_H, ST_SET_AH});
    edit_m  = (state_q inside {ST_SET_M, ST_SET_AM});
    tens_on = ~(fmt12_i && hb[7:4] == 4'd0);

    disp_d[7] = {(edit_h ? show : 1'b1) & tens_on, hb[7:4], 1'b0};
    disp_d[6] = {edit_h ? show : 1'b1, hb[3:0], colon};
    disp_d[5] = {edit_m ? show : 1'b1, mb[7:4], 1'b0};
    disp_d[4] = {edit_m ? show : 1'b1, mb[3:0], colon};
    disp_d[3] = {1'b1, sb[7:4], 1'b0};
    disp_d[2] = {1'b1, sb[3:0], 1'b0};
    disp_d[1] = {1'b1, 1'b0, state_q, 1'b0};
    disp_d[0] = {alarm_en_i, alarm_en_i ? 4'hA : 4'h0, fmt12_i & pm};
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      disp_q     <= '0;
      alarm_q    <= 1'b0;
      sec_tick_q <= 1'b0;
    end else begin
      disp_q     <= disp_d;
      alarm_q    <= ring_q;
      sec_tick_q <= tick;
    end
  end

  assign d8         = disp_q[7];
  assign d7         = disp_q[6];
  assign d6         = disp_q[5];
  assign d5         = disp_q[4];
  assign d4         = disp_q[3];
  assign d3         = disp_q[2];
  assign d2         = disp_q[1];
  assign d1         = disp_q[0];
  assign alarm_o    = alarm_q;
  assign sec_tick_o = sec_tick_q;

endmodule
